debug_slave_cmd_fifo: RTL
=========================

# debug_slave_cmd_fifo

Parametrised clock-domain receiver for the JTAG debug slave. It sits between the virtual-JTAG shift logic and the CPU's on-chip debug (OCI) units. It synchronises the update-DR and update-IR strobes into the system clock domain and captures the IR and DR contents on each update-DR. Captured commands are queued in a FIFO with a valid/ready handshake, so the CPU may stall without losing commands. Each command is decoded into one-hot action and no-action strobes per IR code, and lost commands are recorded in a sticky overrun flag.

## Interface
- IR_W, 2, IR width; the decode produces 2**IR_W channels.
- DATA_W, 38, width of the captured data register.
- SYNC_STAGES, 2, synchroniser depth; must be ≥2.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ACT_BIT, 35, data bit that selects action (1) or no-action (0).
- FLUSH_ON_UIR, 0, 1 = each update-IR edge empties the FIFO.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vs_udr  in  1  update-DR level, asynchronous to clk.
- vs_uir  in  1  update-IR level, asynchronous to clk.
- ir_in  in  IR_W  IR contents; stable while vs_udr is high.
- sr  in  DATA_W  shift register contents; stable while vs_udr is high.
- cmd_ready  in  1  consumer accepts the head entry.
- overrun_clr  in  1  clears overrun.
- cmd_valid  out  1  FIFO head is valid.
- cmd_ir  out  IR_W  head IR.
- cmd_data  out  DATA_W  head data (jdo).
- take_action  out  2**IR_W  one-hot; bit cmd_ir = cmd_valid & cmd_data[ACT_BIT].
- take_no_action  out  2**IR_W  one-hot; bit cmd_ir = cmd_valid & ~cmd_data[ACT_BIT].
- uir_pulse  out  1  one-cycle pulse per update-IR edge.
- fifo_level  out  $clog2(DEPTH+1)  current occupancy.
- overrun  out  1  sticky; set when a command is dropped.

## Operation
- Reset values: all outputs 0; FIFO empty; pointers 0; synchroniser flops 0; armed flags 0.
- Strobe synchroniser, one per strobe:
  - SYNC_STAGES-flop chain, then a delay flop.
  - The armed flag sets once the synchronised level is seen low.
  - An edge is detected when the synchronised level is 1, the delayed level is 0, and armed is 1.
  - Effect: a strobe already high across reset release produces no edge.
- Update-DR edge: in the same cycle, {ir_in, sr} is written at the write pointer.
  - Push is accepted if fifo_level < DEPTH, or if fifo_level == DEPTH and a pop occurs in the same cycle.
  - Otherwise the command is dropped and overrun sets.
- Pop: when cmd_valid & cmd_ready. The read pointer advances; the head is shown combinationally from the read-pointer entry.
- Simultaneous push and pop: fifo_level is unchanged; both pointers advance.
- Empty FIFO: no bypass; a pushed entry appears on the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Overrun: set has priority over overrun_clr in the same cycle.
- Update-IR edge: uir_pulse is high for one cycle. With FLUSH_ON_UIR=1, the FIFO empties in that cycle.
  - The flush overrides a same-cycle pop.
  - A same-cycle update-DR push is still written after the flush, leaving level 1.
- The take_action and take_no_action vectors are zero whenever cmd_valid is 0.

## Timing
- Let k be the first clk edge that samples vs_udr high. The write occurs at edge k+SYNC_STAGES; cmd_valid is high after that edge.
- Strobes must be high for ≥SYNC_STAGES+1 clk periods and low for ≥SYNC_STAGES+1 clk periods between strobes.
- ir_in and sr must be stable from vs_udr rising until SYNC_STAGES+1 clk periods later.
- cmd_ready to pop takes effect in the same cycle; the next head is visible after the edge.
- Throughput: one pop per cycle; one push per strobe.

## Structure
- Package debug_slave_pkg holds:
  - IR code constants: IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3.
  - Default ACT_BIT.
  - A function for the one-hot decode.
- Sub-module debug_strobe_sync (parameter SYNC_STAGES; ports clk, reset_n, async_in, edge_pulse) is instantiated twice.
- The FIFO storage and pointers are written inline in the top level.

## Test plan
- Reset release with vs_udr held high → no push; fifo_level=0; then drop vs_udr and raise it again → exactly one entry.
- Defaults, ir_in=2, sr bit 35 = 1, sr=38'h8_0000_0012, cmd_ready=1 → after edge k+2: cmd_valid=1, cmd_data=38'h8_0000_0012, take_action=4'b0100 for one cycle.
- DEPTH=4, cmd_ready=0, 5 update-DR strobes → fifo_level=4 and overrun=1; popping returns the first four entries in order.
- FIFO full, 5th strobe edge coincides with a pop → no overrun; fifo_level stays 4; the 5th entry is last out.
- overrun=1, overrun_clr held high while a drop occurs → overrun stays 1; clear alone → 0.
- FLUSH_ON_UIR=1, level 3, vs_uir strobe → uir_pulse for 1 cycle; fifo_level=0 and cmd_valid=0 on the next cycle.

Source files
------------

// File: rtl/debug_slave_cmd_fifo_pkg.sv
// Shared constants and the per-IR one-hot decode used by the JTAG debug slave.
package debug_slave_pkg;

  localparam int IR_OCIMEM       = 0;
  localparam int IR_TRACEMEM     = 1;
  localparam int IR_BREAK        = 2;
  localparam int IR_TRACECTRL    = 3;
  localparam int ACT_BIT_DEFAULT = 35;

  // Decode is sized for the widest IR we support; callers truncate to 2**IR_W.
  localparam int MAX_IR_W = 4;

  function automatic logic [2**MAX_IR_W-1:0] onehot_decode(input logic [MAX_IR_W-1:0] code,
                                                           input logic                en);
    logic [2**MAX_IR_W-1:0] vec;
    vec = '0;
    if (en) vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/debug_slave_cmd_fifo_strobe_sync.sv
// Synchronises one asynchronous strobe level into clk and emits a one-cycle
// pulse on its rising edge, ignoring a strobe that was already high at reset.
module debug_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   delay_q;
  logic                   armed_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // fill_q marks when the chain output holds a real sample rather than its
  // reset zero, so arming only happens on a genuinely observed low level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      delay_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      delay_q <= level;
      if (fill_q[SYNC_STAGES-1] && !level) armed_q <= 1'b1;
    end
  end

  assign edge_pulse = level & ~delay_q & armed_q;

endmodule

// File: rtl/debug_slave_cmd_fifo.sv
// JTAG debug slave receiver: captures {IR, DR} on each update-DR strobe into a
// small FIFO and decodes the head entry into per-IR action strobes.
module debug_slave_cmd_fifo
  import debug_slave_pkg::*;
#(
  parameter int IR_W         = 2,
  parameter int DATA_W       = 38,
  parameter int SYNC_STAGES  = 2,
  parameter int DEPTH        = 4,
  parameter int ACT_BIT      = ACT_BIT_DEFAULT,
  parameter int FLUSH_ON_UIR = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [DATA_W-1:0]            sr,
  input  logic                         cmd_ready,
  input  logic                         overrun_clr,
  output logic                         cmd_valid,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [DATA_W-1:0]            cmd_data,
  output logic [2**IR_W-1:0]           take_action,
  output logic [2**IR_W-1:0]           take_no_action,
  output logic                         uir_pulse,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overrun
);

  localparam int NCH   = 2**IR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int ENT_W = IR_W + DATA_W;

  logic             udr_edge;
  logic             uir_edge;
  logic             pop;
  logic             push;
  logic             drop;
  logic             flush;
  logic             full;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] mem [DEPTH];

  debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (vs_udr),
    .edge_pulse (udr_edge)
  );

  debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (vs_uir),
    .edge_pulse (uir_edge)
  );

  assign full  = (fifo_level == LVL_W'(DEPTH));
  assign pop   = cmd_valid & cmd_ready;
  assign flush = (FLUSH_ON_UIR != 0) & uir_edge;
  // A full FIFO still takes the command if a pop or flush frees room this cycle.
  assign push  = udr_edge & (flush | ~full | pop);
  assign drop  = udr_edge & ~push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {ir_in, sr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      // Flushing jumps the read pointer to the pre-push write pointer, so a
      // same-cycle push becomes the sole surviving entry.
      if (flush) begin
        rd_ptr     <= wr_ptr;
        fifo_level <= push ? LVL_W'(1) : '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fifo_level <= fifo_level + 1'b1;
          2'b01:   fifo_level <= fifo_level - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

  assign cmd_valid         = (fifo_level != '0);
  assign {cmd_ir, cmd_data} = mem[rd_ptr];
  assign uir_pulse         = uir_edge;

  assign take_action    = NCH'(onehot_decode(MAX_IR_W'(cmd_ir), cmd_valid &  cmd_data[ACT_BIT]));
  assign take_no_action = NCH'(onehot_decode(MAX_IR_W'(cmd_ir), cmd_valid & ~cmd_data[ACT_BIT]));

endmodule
